// File: rtl/ddr_arbiter.sv
// SDRAM command arbiter: display reads, draw writes and auto-refresh with postponable refresh debt.
// Latency: request seen in IDLE at edge N is presented on cmdValid after edge N; grants combinational on transfer.
// Backpressure: cmdValid/cmdOp/cmdAddr held until cmdReady; requests are not re-sampled while a command is pending.
// Optional feature: define DDR_ARB_STARVE_EN to let a starved draw request outrank display.
module ddr_arbiter #(
    parameter int REFRESH_INTERVAL = 1040,
    parameter int MAX_POSTPONE     = 8,
    parameter int ADDR_W           = 24,
    parameter int STARVE_LIMIT     = 4
) (
    input  logic              clk133,
    input  logic              rst_n,
    input  logic              initDone,
    input  logic              dispReq,
    input  logic [ADDR_W-1:0] dispAddr,
    output logic              dispGnt,
    input  logic              drawReq,
    input  logic [ADDR_W-1:0] drawAddr,
    output logic              drawGnt,
    output logic              cmdValid,
    output logic [1:0]        cmdOp,
    output logic [ADDR_W-1:0] cmdAddr,
    input  logic              cmdReady,
    output logic [3:0]        refreshOwed,
    output logic              refreshErr
);

    localparam int                TICK_W   = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [TICK_W-1:0] TICK_TOP = TICK_W'(REFRESH_INTERVAL - 1);
    localparam logic [3:0]        OWED_MAX = 4'(MAX_POSTPONE);

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_REFRESH = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_t;

    state_t              state_q, state_d;
    logic                cmd_vld_q, cmd_vld_d;
    logic [1:0]          cmd_op_q, cmd_op_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]          owed_q, owed_d;
    logic                err_q, err_d;

    logic                xfer;
    logic                refresh_xfer;
    logic                tick;
    logic                owed_full;
    logic                starve_win;

    logic                sel_vld;
    logic [1:0]          sel_op;
    logic [ADDR_W-1:0]   sel_addr;

    assign xfer         = cmd_vld_q & cmdReady;
    assign refresh_xfer = xfer & (cmd_op_q == OP_REFRESH);
    assign tick         = initDone & (tick_cnt_q == TICK_TOP);
    assign owed_full    = (owed_q >= OWED_MAX);

    assign dispGnt     = xfer & (cmd_op_q == OP_READ);
    assign drawGnt     = xfer & (cmd_op_q == OP_WRITE);
    assign cmdValid    = cmd_vld_q;
    assign cmdOp       = cmd_op_q;
    assign cmdAddr     = cmd_addr_q;
    assign refreshOwed = owed_q;
    assign refreshErr  = err_q;

    // Free-running refresh interval counter; its wrap cycle is the refresh tick.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (!initDone) begin
            tick_cnt_d = '0;
        end else if (tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
    end

    // Refresh debt: ticks add, refresh transfers subtract, both together cancel; overflowing tick is sticky error.
    always_comb begin
        owed_d = owed_q;
        err_d  = err_q;
        if (!initDone) begin
            owed_d = '0;
        end else begin
            if (tick && owed_full) begin
                err_d = 1'b1;
            end
            if (tick && !refresh_xfer && !owed_full) begin
                owed_d = owed_q + 4'd1;
            end else if (refresh_xfer && !tick && (owed_q != 4'd0)) begin
                owed_d = owed_q - 4'd1;
            end
        end
    end

`ifdef DDR_ARB_STARVE_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;

    // Count display wins while draw waits; any gap in drawReq or a draw win restarts the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!initDone || !drawReq) begin
            starve_cnt_d = '0;
        end else if (drawGnt) begin
            starve_cnt_d = '0;
        end else if (dispGnt && (starve_cnt_q != 4'hF)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk133 or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve_win = drawReq & (starve_cnt_q == 4'(STARVE_LIMIT));
`else
    assign starve_win = 1'b0;
`endif

    // Winner selection: urgent refresh, starved draw, display, draw, then opportunistic refresh.
    always_comb begin
        sel_vld  = 1'b1;
        sel_op   = OP_REFRESH;
        sel_addr = '0;
        if (owed_full) begin
            sel_op   = OP_REFRESH;
            sel_addr = '0;
        end else if (starve_win) begin
            sel_op   = OP_WRITE;
            sel_addr = drawAddr;
        end else if (dispReq) begin
            sel_op   = OP_READ;
            sel_addr = dispAddr;
        end else if (drawReq) begin
            sel_op   = OP_WRITE;
            sel_addr = drawAddr;
        end else if (owed_q != 4'd0) begin
            sel_op   = OP_REFRESH;
            sel_addr = '0;
        end else begin
            sel_vld  = 1'b0;
        end
    end

    // Command FSM: IDLE loads the winner, ISSUE holds it until the controller accepts.
    always_comb begin
        state_d    = state_q;
        cmd_vld_d  = cmd_vld_q;
        cmd_op_d   = cmd_op_q;
        cmd_addr_d = cmd_addr_q;
        if (!initDone) begin
            state_d   = ST_IDLE;
            cmd_vld_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_vld) begin
                        state_d    = ST_ISSUE;
                        cmd_vld_d  = 1'b1;
                        cmd_op_d   = sel_op;
                        cmd_addr_d = sel_addr;
                    end
                end
                ST_ISSUE: begin
                    if (cmdReady) begin
                        state_d   = ST_IDLE;
                        cmd_vld_d = 1'b0;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    cmd_vld_d = 1'b0;
                end
            endcase
        end
    end

    // State, command, tick and debt registers.
    always_ff @(posedge clk133 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_vld_q  <= 1'b0;
            cmd_op_q   <= 2'b00;
            cmd_addr_q <= '0;
            tick_cnt_q <= '0;
            owed_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_vld_q  <= cmd_vld_d;
            cmd_op_q   <= cmd_op_d;
            cmd_addr_q <= cmd_addr_d;
            tick_cnt_q <= tick_cnt_d;
            owed_q     <= owed_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: doc/ddr_arbiter.md
# ddr_arbiter

Sits between the DDR controller's command port and its requesters, running on the 133 MHz memory clock. Shares the SDRAM between the display scan-out reader, the drawing-engine writer and periodic auto-refresh. Tracks refresh debt so refreshes are postponed while traffic is heavy and forced before the debt limit is exceeded. Presents one command at a time to the controller through a valid/ready handshake.

## Interface

Parameters:
- REFRESH_INTERVAL, 1040: clk133 cycles per refresh tick (7.8 µs at 133 MHz).
- MAX_POSTPONE, 8: maximum owed refreshes; range 1..15.
- ADDR_W, 24: request address width (bank/row/column, packed by the controller).
- STARVE_LIMIT, 4: consecutive display grants after which a waiting draw request wins (only with macro).

Ports:
- clk133 in 1: memory clock; all logic is on its rising edge.
- rst_n in 1: asynchronous, active-low reset.
- initDone in 1: controller initialization complete; level.
- dispReq in 1: display read request; held until dispGnt.
- dispAddr in ADDR_W: display address; stable while dispReq is high.
- dispGnt out 1: one-cycle pulse on the transfer of a display command.
- drawReq in 1: draw write request; held until drawGnt.
- drawAddr in ADDR_W: draw address; stable while drawReq is high.
- drawGnt out 1: one-cycle pulse on the transfer of a draw command.
- cmdValid out 1: command presented to the controller.
- cmdOp out 2: 00 read, 01 write, 10 refresh.
- cmdAddr out ADDR_W: command address; 0 for refresh.
- cmdReady in 1: controller accepts; a transfer occurs when cmdValid and cmdReady are both high.
- refreshOwed out 4: current refresh debt.
- refreshErr out 1: sticky; a refresh tick arrived while debt was already MAX_POSTPONE.

## Operation

- Reset: all outputs 0; state IDLE; tick counter, debt and starvation counter 0.
- initDone low: state forced to IDLE. cmdValid, refreshOwed, the tick counter and the starvation counter are cleared synchronously. No grants are issued.
- Tick counter:
  - Counts 0..REFRESH_INTERVAL-1 while initDone is high and wraps at the top.
  - The wrap cycle is a tick.
  - A tick increments refreshOwed, saturating at MAX_POSTPONE.
  - A tick at saturation sets refreshErr.
  - A refresh transfer decrements refreshOwed.
  - A tick and a refresh transfer in the same cycle leave refreshOwed unchanged.
- State IDLE selects a winner, in this priority order:
  1. Urgent refresh (refreshOwed == MAX_POSTPONE).
  2. Display.
  3. Draw.
  4. Opportunistic refresh (refreshOwed > 0 with no requests pending).
  - The winner's op/addr are registered into cmdOp/cmdAddr, cmdValid is set, and the state moves to ISSUE.
- State ISSUE:
  - cmdValid/cmdOp/cmdAddr are held stable until cmdReady.
  - On transfer, the matching dispGnt or drawGnt is driven high combinationally in the same cycle; cmdValid clears at the next edge and the state returns to IDLE.
- Requests are not re-sampled during ISSUE. A requester dropping its req mid-ISSUE is a protocol violation; the command still completes.

## Timing

- Request to cmdValid: 1 cycle (request seen in IDLE at edge N gives cmdValid high after edge N).
- Minimum spacing: one IDLE cycle between transfers, so at most 1 command per 2 cycles.
- Grant is combinational from cmdReady; requesters must drop or advance req/addr at the following edge.
- First tick: REFRESH_INTERVAL cycles after initDone rises.
- Urgent refresh preempts selection at the next IDLE cycle. It never aborts a command already in ISSUE.

## Configuration

- DDR_ARB_STARVE_EN defined:
  - A 4-bit counter counts display transfers that occur while drawReq is high.
  - It clears on a draw transfer or whenever drawReq is low.
  - When the count equals STARVE_LIMIT and drawReq is high, draw outranks display. Urgent refresh still outranks both.
- Undefined: strict priority as listed under Operation; no starvation counter is built.

## Test plan

All scenarios use REFRESH_INTERVAL=16 and MAX_POSTPONE=2.

- Reset/init: rst_n low, then initDone=0 with dispReq=1 → cmdValid stays 0 and refreshOwed=0. Raise initDone → first tick 16 cycles later and refreshOwed=1.
- Basic grant: dispReq=1, dispAddr=0x00ABCD, cmdReady=1 → cmdValid next cycle with cmdOp=00 and cmdAddr=0x00ABCD; dispGnt pulses 1 cycle; back-to-back requests give transfers every 2 cycles.
- Priority: dispReq and drawReq both high → display granted first, draw on the following transfer with cmdOp=01. With no requests and refreshOwed=1 → cmdOp=10 issued, refreshOwed goes to 0.
- Refresh urgency: continuous dispReq with cmdReady=1 for 40 cycles → refreshOwed reaches 2, the next selection is a refresh, and refreshErr stays 0. Hold cmdReady=0 for 20 cycles at debt 2 → a tick sets refreshErr=1.
- Handshake stall and simultaneity: cmdReady=0 for 5 cycles → cmdOp/cmdAddr stable and no grant. A refresh transfer on a tick cycle leaves refreshOwed unchanged.
- Starvation (macro on, STARVE_LIMIT=4): dispReq and drawReq held high → 4 display grants, then 1 draw grant, then the counter restarts.
